// File: rtl/up_dn_counter_ctrl.sv
// Command-side driver for a saturating up/down counter: accepts a target request,
// then loads or steps the counter until its count matches, and reports done/err.
module up_dn_counter_ctrl #(
    parameter int WIDTH     = 5,
    parameter int MAX_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic             req_mode,
    input  logic [WIDTH-1:0] cnt_count,
    input  logic             cnt_high,
    input  logic             cnt_low,
    output logic [WIDTH-1:0] cnt_in,
    output logic             cnt_load,
    output logic             cnt_up,
    output logic             cnt_down,
    output logic             done,
    output logic             err
);

    localparam int SW = $clog2(MAX_STEPS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        STEP,
        RESP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
    logic             mode;
    logic [SW-1:0]    step_cnt;
    logic             err_flag;

    logic need_up;
    logic need_down;
    logic at_limit;
    logic blocked;
    logic step_active;

    assign need_up     = cnt_count < target;
    assign need_down   = cnt_count > target;
    assign at_limit    = step_cnt == SW'(MAX_STEPS);
    // Feedback contradicting the required direction means the counter cannot move.
    assign blocked     = (need_up && cnt_high) || (need_down && cnt_low);
    assign step_active = (state == STEP) && !mode && !at_limit && !blocked;

    assign req_ready = (state == IDLE);
    assign cnt_in    = target;
    assign cnt_load  = (state == LOAD);
    assign cnt_up    = step_active && need_up;
    assign cnt_down  = step_active && need_down;
    assign done      = (state == RESP);
    assign err       = (state == RESP) && err_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            target   <= '0;
            mode     <= 1'b0;
            step_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        target   <= req_target;
                        mode     <= req_mode;
                        step_cnt <= '0;
                        err_flag <= 1'b0;
                        state    <= req_mode ? LOAD : STEP;
                    end
                end
                LOAD: begin
                    state <= VERIFY;
                end
                VERIFY: begin
                    err_flag <= (cnt_count != target);
                    state    <= RESP;
                end
                STEP: begin
                    if (!need_up && !need_down) begin
                        err_flag <= 1'b0;
                        state    <= RESP;
                    end else if (at_limit || blocked) begin
                        err_flag <= 1'b1;
                        state    <= RESP;
                    end else begin
                        step_cnt <= step_cnt + SW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
